delay_line_prog: RTL and testbench

Parametrised, synthesizable, multi-channel delay line for the request/acknowledge wires of the bundled-data booth multiplier pipeline. Each channel delays one handshake wire by a runtime-programmable number of clock cycles, from 0 (pass-through) to MAX_DELAY. Per-stage matched delays can then be tuned on hardware without re-synthesis. The block sits between each stage controller's req/ack outputs and the neighbouring controller's inputs.

---
 rtl/delay_pkg.sv | 13 +
 rtl/delay_tap.sv | 43 ++++
 rtl/delay_line_prog.sv | 69 ++++++
 tb/tb_delay_line_prog.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared defaults and width helper for the programmable handshake delay line.
package delay_pkg;

   localparam int unsigned NCH_DEF         = 4;
   localparam int unsigned MAX_DELAY_DEF   = 16;
   localparam int unsigned RESET_DELAY_DEF = 2;

   // Bits needed to index n items, never less than one.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/delay_tap.sv
// One delay channel: free-running shift register, programmable tap and idle detect.
module delay_tap
   import delay_pkg::*;
#(
   parameter int unsigned MAX_DELAY   = MAX_DELAY_DEF,
   parameter int unsigned RESET_DELAY = RESET_DELAY_DEF,
   parameter int unsigned DW          = clog2_min1(MAX_DELAY + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_delay,
   output logic          dout,
   output logic          idle,
   output logic [DW-1:0] delay
);

   localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
   localparam logic [DW-1:0] RST_D = DW'(RESET_DELAY);

   logic [MAX_DELAY-1:0] sr;
   logic [MAX_DELAY:0]   taps;

   // taps[0] is the live input, taps[k] is stage k.
   assign taps = {sr, din};

   always_ff @(posedge clk) begin
      if (rst) begin
         sr    <= '0;
         delay <= RST_D;
      end else begin
         sr <= taps[MAX_DELAY-1:0];
         if (wr_en) begin
            delay <= (wr_delay > MAX_D) ? MAX_D : wr_delay;
         end
      end
   end

   assign dout = taps[delay];
   assign idle = (sr == {MAX_DELAY{din}});

endmodule

// File: rtl/delay_line_prog.sv
// Multi-channel programmable delay line for bundled-data req/ack wires.
module delay_line_prog
   import delay_pkg::*;
#(
   parameter  int unsigned NCH         = NCH_DEF,
   parameter  int unsigned MAX_DELAY   = MAX_DELAY_DEF,
   parameter  int unsigned RESET_DELAY = RESET_DELAY_DEF,
   localparam int unsigned DW          = clog2_min1(MAX_DELAY + 1),
   localparam int unsigned CW          = clog2_min1(NCH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NCH-1:0]  din,
   output logic [NCH-1:0]  dout,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [CW-1:0]   cfg_ch,
   input  logic [DW-1:0]   cfg_delay,
   output logic            cfg_err,
   output logic [NCH-1:0]  ch_idle,
   output logic [NCH*DW-1:0] delay_rd
);

   localparam int unsigned NSLOT = 1 << CW;

   logic             ch_ok;
   logic             accept;
   logic [NSLOT-1:0] idle_pad;

   // Every encodable index is a real channel when NCH fills the index space.
   if (NSLOT == NCH) begin : g_full
      assign ch_ok = 1'b1;
   end else begin : g_part
      assign ch_ok = (cfg_ch < CW'(NCH));
   end

   assign idle_pad  = NSLOT'(ch_idle);
   assign cfg_ready = ch_ok ? idle_pad[cfg_ch] : 1'b1;
   assign accept    = cfg_valid & cfg_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_valid & ~ch_ok;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic wr_en;
      assign wr_en = accept & ch_ok & (cfg_ch == CW'(c));

      delay_tap #(
         .MAX_DELAY   (MAX_DELAY),
         .RESET_DELAY (RESET_DELAY),
         .DW          (DW)
      ) u_tap (
         .clk      (clk),
         .rst      (rst),
         .din      (din[c]),
         .wr_en    (wr_en),
         .wr_delay (cfg_delay),
         .dout     (dout[c]),
         .idle     (ch_idle[c]),
         .delay    (delay_rd[c*DW +: DW])
      );
   end

endmodule

// File: tb/tb_delay_line_prog.sv
// Directed and reference-model checks for delay_line_prog.
module tb_delay_line_prog;

   localparam int unsigned NCH = 4, MAXD = 16, DW = 5, CW = 2;
   localparam int unsigned E_NCH = 3, E_MAXD = 4, E_DW = 3, E_CW = 2;

   logic clk = 1'b0;
   logic rst;

   logic [NCH-1:0]    din, dout, ch_idle;
   logic              cfg_valid, cfg_ready, cfg_err;
   logic [CW-1:0]     cfg_ch;
   logic [DW-1:0]     cfg_delay;
   logic [NCH*DW-1:0] delay_rd;

   logic [E_NCH-1:0]      e_din, e_dout, e_ch_idle;
   logic                  e_cfg_valid, e_cfg_ready, e_cfg_err;
   logic [E_CW-1:0]       e_cfg_ch;
   logic [E_DW-1:0]       e_cfg_delay;
   logic [E_NCH*E_DW-1:0] e_delay_rd;

   delay_line_prog #(.NCH(NCH), .MAX_DELAY(MAXD), .RESET_DELAY(2)) u_dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_delay(cfg_delay), .cfg_err(cfg_err), .ch_idle(ch_idle),
      .delay_rd(delay_rd)
   );

   // Partially filled channel space so that out-of-range indices exist.
   delay_line_prog #(.NCH(E_NCH), .MAX_DELAY(E_MAXD), .RESET_DELAY(0)) u_err (
      .clk(clk), .rst(rst), .din(e_din), .dout(e_dout),
      .cfg_valid(e_cfg_valid), .cfg_ready(e_cfg_ready), .cfg_ch(e_cfg_ch),
      .cfg_delay(e_cfg_delay), .cfg_err(e_cfg_err), .ch_idle(e_ch_idle),
      .delay_rd(e_delay_rd)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rd(input int ch);
      return delay_rd[ch*DW +: DW];
   endfunction

   // Counts output transitions per channel, sampled just after each falling edge.
   logic [NCH-1:0] mon_prev = '0;
   int tog[NCH];
   always @(negedge clk) begin
      #2;
      for (int c = 0; c < NCH; c++) if (dout[c] !== mon_prev[c]) tog[c]++;
      mon_prev = dout;
   end

   task automatic cfg_write(input int ch, input int d, output int waited);
      cfg_ch    = CW'(ch);
      cfg_delay = DW'(d);
      cfg_valid = 1'b1;
      waited    = 0;
      #1;
      while (!cfg_ready && waited < 100) begin
         @(negedge clk);
         #1;
         waited++;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic measure(input int ch, output int lat);
      din[ch] = ~din[ch];
      #1;
      lat = 0;
      while (dout[ch] !== din[ch] && lat < 40) begin
         @(negedge clk);
         #1;
         lat++;
      end
   endtask

   typedef struct {
      int ch;
      int req;
      int exp_delay;
      int exp_lat;
   } vec_t;

   vec_t vecs[7];
   int   hist[NCH][MAXD+1];
   int   md[NCH];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat, w, acc;
      logic [NCH-1:0] exp_dout;
      logic mready;

      vecs[0] = '{1, 7, 7, 7};
      vecs[1] = '{1, 0, 0, 0};
      vecs[2] = '{3, 31, 16, 16};
      vecs[3] = '{0, 16, 16, 16};
      vecs[4] = '{2, 1, 1, 1};
      vecs[5] = '{3, 5, 5, 5};
      vecs[6] = '{0, 2, 2, 2};

      rst = 1'b1; din = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_delay = '0;
      e_din = 3'b101; e_cfg_valid = 1'b0; e_cfg_ch = '0; e_cfg_delay = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_delay_rd", 64'(delay_rd), 64'({4{5'd2}}));
      check("rst_cfg_err", 64'(cfg_err), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_idle", 64'(ch_idle), 64'hf);
      check("e_rst_dout_passthru", 64'(e_dout), 64'b101);
      check("e_rst_delay_rd", 64'(e_delay_rd), 64'd0);
      rst = 1'b0;

      repeat (7) @(negedge clk);
      measure(0, lat);
      check("rst_default_latency", 64'(lat), 64'd2);
      repeat (20) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         cfg_write(vecs[i].ch, vecs[i].req, w);
         check($sformatf("tbl%0d_ready_wait", i), 64'(w), 64'd0);
         #1;
         check($sformatf("tbl%0d_delay_rd", i), 64'(rd(vecs[i].ch)), 64'(vecs[i].exp_delay));
         measure(vecs[i].ch, lat);
         check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         repeat (20) @(negedge clk);
         #1;
         check($sformatf("tbl%0d_idle", i), 64'(ch_idle[vecs[i].ch]), 64'd1);
      end
      check("cfg_err_never_valid_ch", 64'(cfg_err), 64'd0);

      // Busy stall: channel 2 (delay 1) gets a toggle, then a write the next cycle.
      @(negedge clk);
      tog[2] = 0;
      din[2] = ~din[2];
      @(negedge clk);
      cfg_write(2, 5, w);
      check("stall_cycles", 64'(w), 64'd15);
      #1;
      check("stall_delay_rd", 64'(rd(2)), 64'd5);
      repeat (25) @(negedge clk);
      check("stall_toggles", 64'(tog[2]), 64'd1);

      // Reset mid-flight, with a concurrent write that reset must override.
      din = '0;
      repeat (20) @(negedge clk);
      tog[0] = 0;
      din[0] = 1'b1;
      @(negedge clk);
      rst = 1'b1; din[0] = 1'b0;
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_delay = 5'd9;
      @(negedge clk);
      rst = 1'b0; cfg_valid = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("midflight_toggles", 64'(tog[0]), 64'd0);
      check("midflight_delay_rd", 64'(delay_rd), 64'({4{5'd2}}));
      check("midflight_dout", 64'(dout), 64'd0);

      // Random regression against a per-channel history reference.
      for (int c = 0; c < NCH; c++) begin
         md[c] = 2;
         for (int k = 0; k <= MAXD; k++) hist[c][k] = 0;
      end
      acc = 0;
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         if ((t % 80) < 15) begin
            for (int c = 0; c < NCH; c++) if ($urandom_range(3) == 0) din[c] = ~din[c];
         end
         cfg_valid = ($urandom_range(2) == 0);
         cfg_ch    = CW'($urandom_range(3));
         cfg_delay = DW'($urandom_range(20));
         #1;
         for (int c = 0; c < NCH; c++) begin
            hist[c][0]  = int'(din[c]);
            exp_dout[c] = hist[c][md[c]][0];
         end
         mready = 1'b1;
         for (int k = 1; k <= MAXD; k++)
            if (hist[cfg_ch][k] != hist[cfg_ch][0]) mready = 1'b0;
         check("rand_dout", 64'(dout), 64'(exp_dout));
         check("rand_ready", 64'(cfg_ready), 64'(mready));
         if (cfg_valid && mready) begin
            md[cfg_ch] = (int'(cfg_delay) > MAXD) ? MAXD : int'(cfg_delay);
            acc++;
         end
         for (int c = 0; c < NCH; c++)
            for (int k = MAXD; k >= 1; k--) hist[c][k] = hist[c][k-1];
      end
      cfg_valid = 1'b0;
      check("rand_writes_seen", 64'(acc > 0), 64'd1);

      // Clamp and bad-channel error on the partial-index instance.
      @(negedge clk);
      e_cfg_ch = 2'd1; e_cfg_delay = 3'd7; e_cfg_valid = 1'b1;
      #1;
      check("e_ready_idle", 64'(e_cfg_ready), 64'd1);
      @(negedge clk);
      e_cfg_valid = 1'b0;
      #1;
      check("e_clamp", 64'(e_delay_rd), 64'({3'd0, 3'd4, 3'd0}));
      check("e_err_valid_ch", 64'(e_cfg_err), 64'd0);
      e_cfg_ch = 2'd3; e_cfg_delay = 3'd5; e_cfg_valid = 1'b1;
      #1;
      check("e_ready_bad_ch", 64'(e_cfg_ready), 64'd1);
      check("e_err_before_edge", 64'(e_cfg_err), 64'd0);
      @(negedge clk);
      e_cfg_valid = 1'b0;
      #1;
      check("e_err_pulse", 64'(e_cfg_err), 64'd1);
      check("e_err_no_change", 64'(e_delay_rd), 64'({3'd0, 3'd4, 3'd0}));
      @(negedge clk);
      #1;
      check("e_err_one_cycle", 64'(e_cfg_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
